ctrl_pipe_unit: RTL and testbench
=================================

Name: ctrl_pipe_unit

Overview:
Parametrised successor of the single-cycle MIPS control decoder for the 5-stage pipelined CPU. It decodes the ID-stage instruction into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards (stall), applies EX-resolved redirects (flush), runs the syscall-exit halt FSM, and keeps stall/flush statistics counters.

Parameters:
ALUOP_W, 4, ALU opcode width; codes are zero-extended into this width.
CNT_W, 16, width of the stall/flush statistics counters (saturating).
DRAIN_CYC, 2, cycles the pipeline drains after an exit syscall leaves EX before halt asserts (range 1..3).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
id_instr  in  32  instruction in IF/ID register
id_valid  in  1  IF/ID holds a real instruction (0 = bubble)
ex_redirect  in  1  taken branch, jump or jr resolved in EX this cycle
ex_sys_exit  in  1  $v0==10 for the syscall currently in EX
resume  in  1  one-cycle pulse that leaves HALT
pc_stall  out  1  hold PC (combinational)
ifid_stall  out  1  hold IF/ID (combinational)
ifid_flush  out  1  clear IF/ID (combinational)
ex_aluop  out  ALUOP_W  ID/EX ALU opcode
ex_alusrc, ex_extop[1:0], ex_j, ex_jal, ex_jr, ex_beq, ex_bne, ex_blez, ex_syscall  out  1/2  ID/EX control fields
ex_wreg  out  5  ID/EX destination register
mem_memwrite, mem_sh, mem_memtoreg, mem_regwrite  out  1  EX/MEM control fields
mem_wreg  out  5  EX/MEM destination register
wb_regwrite, wb_memtoreg, wb_jal  out  1  MEM/WB control fields
wb_wreg  out  5  MEM/WB destination register
halt  out  1  CPU halted
stall_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  redirect flushes

Behaviour:
- Reset (async, rst_n=0): all stage registers cleared to bubble (every control 0, wreg 0); FSM=RUN; halt=0; counters=0.
- Decode covers add, addu, sub, and, or, xor, nor, slt, sltu, sll, srl, sra, jr, syscall, addi, addiu, andi, ori, slti, sltiu, beq, bne, blez, j, jal, lw, sw, sh. ALU codes: sll 0000, sra 0001, srl 0010, add/addu/addi/addiu/lw/sw/sh 0101, sub 0110, and/andi 0111, or/ori 1000, xor 1001, nor 1010, slt/slti 1011, sltu/sltiu 1100, none 1101. EXTOP: shifts 10, ori 01, others 00.
- Any unlisted op/func, or id_valid=0, decodes to an all-zero bubble. No latched outputs.
- wreg: rd for R-type writers; rt for I-type writers and lw; 31 for jal; 0 when regwrite=0.
- Load-use hazard: ID/EX memtoreg=1, ex_wreg!=0, and ex_wreg equals id_instr rs or rt, with id_valid=1. Response: pc_stall=ifid_stall=1, bubble into ID/EX, stall_cnt+1.
- Redirect: ex_redirect=1 gives ifid_flush=1 and a bubble into ID/EX; flush_cnt+1. Redirect beats a hazard in the same cycle: no stall, and stall_cnt does not increment.
- EX/MEM and MEM/WB always advance, taking the previous stage's bundle each cycle.
- FSM:
  - RUN: ex_syscall=1 and ex_sys_exit=1 go to DRAIN with cnt=DRAIN_CYC. Younger instructions are flushed: ifid_flush=1, ID/EX gets a bubble.
  - DRAIN: pc_stall=ifid_stall=1, bubble into ID/EX, cnt decrements; at cnt==1 go to HALT.
  - HALT: halt=1, pc_stall=ifid_stall=1; resume=1 goes to RUN (halt clears the next cycle).
  - A syscall with ex_sys_exit=0 is a no-op.
- Counters saturate at all-ones. Counting stops in DRAIN and HALT.
- rst_n low mid-DRAIN/HALT returns to RUN with halt=0 immediately (asynchronous).

Optional Feature:
ILLEGAL_TRAP_EN: when defined, adds output illegal (1 bit). An undecodable instruction with id_valid=1 that reaches ID/EX sets a sticky illegal=1 and forces the FSM to HALT on the next cycle; resume clears both. When undefined, the port is absent and undecodable instructions are silent bubbles.

Test Plan:
- Reset with rst_n=0 after arbitrary traffic -> all ex_/mem_/wb_ outputs 0, halt=0, stall_cnt=flush_cnt=0 asynchronously.
- Stream add $3,$1,$2 then lw $4,0($3) -> ex_aluop=0101, ex_wreg=3; two cycles later mem_memtoreg=1, mem_wreg=4; wb_regwrite=1 for both in order.
- lw $5,0($0) followed by add $6,$5,$1 -> exactly one cycle pc_stall=ifid_stall=1, one bubble in ID/EX, stall_cnt=1, then add issues with ex_wreg=6.
- ex_redirect=1 in the same cycle as a load-use hazard -> ifid_flush=1, pc_stall=0, flush_cnt=1, stall_cnt unchanged.
- syscall with ex_sys_exit=1, DRAIN_CYC=2 -> flush, 2 drain cycles, halt=1 on cycle 3; pulse resume -> halt=0 the next cycle; syscall with ex_sys_exit=0 -> no halt.
- jal then an undefined op 0x3F -> wb_jal=1, wb_wreg=31; undefined op gives an all-zero bundle (with ILLEGAL_TRAP_EN: illegal=1 and halt=1).

Source files
------------

// File: rtl/ctrl_pipe_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_unit_if
// Purpose  : Bundles the signals between the pipeline control unit and the
//            datapath. The control unit uses the master modport and the
//            datapath uses the slave modport.
// Signals  : id_instr/id_valid      - IF/ID instruction and valid flag
//            ex_redirect            - EX-resolved taken branch/jump/jr
//            ex_sys_exit            - exit request for the syscall in EX
//            resume                 - one-cycle pulse that leaves HALT
//            pc_stall/ifid_stall    - hold PC / IF/ID (combinational)
//            ifid_flush             - clear IF/ID (combinational)
//            ex_*                   - ID/EX control register fields
//            mem_*                  - EX/MEM control register fields
//            wb_*                   - MEM/WB control register fields
//            halt                   - CPU halted
//            stall_cnt/flush_cnt    - saturating statistics counters
//            illegal                - sticky illegal-op flag (ILLEGAL_TRAP_EN)
// Macro    : ILLEGAL_TRAP_EN adds the illegal signal.
// Revision : 1.0 - initial release
// ============================================================================
interface ctrl_pipe_unit_if #(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
);
    logic [31:0]        id_instr;
    logic               id_valid;
    logic               ex_redirect;
    logic               ex_sys_exit;
    logic               resume;

    logic               pc_stall;
    logic               ifid_stall;
    logic               ifid_flush;

    logic [ALUOP_W-1:0] ex_aluop;
    logic               ex_alusrc;
    logic [1:0]         ex_extop;
    logic               ex_j;
    logic               ex_jal;
    logic               ex_jr;
    logic               ex_beq;
    logic               ex_bne;
    logic               ex_blez;
    logic               ex_syscall;
    logic [4:0]         ex_wreg;

    logic               mem_memwrite;
    logic               mem_sh;
    logic               mem_memtoreg;
    logic               mem_regwrite;
    logic [4:0]         mem_wreg;

    logic               wb_regwrite;
    logic               wb_memtoreg;
    logic               wb_jal;
    logic [4:0]         wb_wreg;

    logic               halt;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;
`ifdef ILLEGAL_TRAP_EN
    logic               illegal;
`endif

    modport master (
        input  id_instr, id_valid, ex_redirect, ex_sys_exit, resume,
        output pc_stall, ifid_stall, ifid_flush,
        output ex_aluop, ex_alusrc, ex_extop, ex_j, ex_jal, ex_jr,
        output ex_beq, ex_bne, ex_blez, ex_syscall, ex_wreg,
        output mem_memwrite, mem_sh, mem_memtoreg, mem_regwrite, mem_wreg,
        output wb_regwrite, wb_memtoreg, wb_jal, wb_wreg,
`ifdef ILLEGAL_TRAP_EN
        output illegal,
`endif
        output halt, stall_cnt, flush_cnt
    );

    modport slave (
        output id_instr, id_valid, ex_redirect, ex_sys_exit, resume,
        input  pc_stall, ifid_stall, ifid_flush,
        input  ex_aluop, ex_alusrc, ex_extop, ex_j, ex_jal, ex_jr,
        input  ex_beq, ex_bne, ex_blez, ex_syscall, ex_wreg,
        input  mem_memwrite, mem_sh, mem_memtoreg, mem_regwrite, mem_wreg,
        input  wb_regwrite, wb_memtoreg, wb_jal, wb_wreg,
`ifdef ILLEGAL_TRAP_EN
        input  illegal,
`endif
        input  halt, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_unit
// Purpose  : Control unit of the 5-stage MIPS pipeline. Decodes the ID-stage
//            instruction into a control bundle, carries it through the ID/EX,
//            EX/MEM and MEM/WB control registers, detects load-use hazards,
//            applies EX redirects, runs the syscall-exit halt FSM and keeps
//            saturating stall/flush counters.
// Ports    : clk   - system clock
//            rst_n - asynchronous active-low reset
//            bus   - ctrl_pipe_unit_if.master (instruction in, control out)
// Params   : ALUOP_W   - ALU opcode width (codes zero-extended)
//            CNT_W     - statistics counter width
//            DRAIN_CYC - drain cycles between exit syscall and halt (1..3)
// Macro    : ILLEGAL_TRAP_EN - undecodable instructions set a sticky illegal
//            flag and halt the CPU; otherwise they are silent bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe_unit #(
    parameter int ALUOP_W   = 4,
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    ctrl_pipe_unit_if.master bus
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_blez  = 6'h06;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_addiu = 6'h09;
    localparam logic [5:0] c_op_slti  = 6'h0A;
    localparam logic [5:0] c_op_sltiu = 6'h0B;
    localparam logic [5:0] c_op_andi  = 6'h0C;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sh    = 6'h29;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_sll     = 6'h00;
    localparam logic [5:0] c_fn_srl     = 6'h02;
    localparam logic [5:0] c_fn_sra     = 6'h03;
    localparam logic [5:0] c_fn_jr      = 6'h08;
    localparam logic [5:0] c_fn_syscall = 6'h0C;
    localparam logic [5:0] c_fn_add     = 6'h20;
    localparam logic [5:0] c_fn_addu    = 6'h21;
    localparam logic [5:0] c_fn_sub     = 6'h22;
    localparam logic [5:0] c_fn_and     = 6'h24;
    localparam logic [5:0] c_fn_or      = 6'h25;
    localparam logic [5:0] c_fn_xor     = 6'h26;
    localparam logic [5:0] c_fn_nor     = 6'h27;
    localparam logic [5:0] c_fn_slt     = 6'h2A;
    localparam logic [5:0] c_fn_sltu    = 6'h2B;

    localparam logic [ALUOP_W-1:0] c_alu_sll  = ALUOP_W'(4'b0000);
    localparam logic [ALUOP_W-1:0] c_alu_sra  = ALUOP_W'(4'b0001);
    localparam logic [ALUOP_W-1:0] c_alu_srl  = ALUOP_W'(4'b0010);
    localparam logic [ALUOP_W-1:0] c_alu_add  = ALUOP_W'(4'b0101);
    localparam logic [ALUOP_W-1:0] c_alu_sub  = ALUOP_W'(4'b0110);
    localparam logic [ALUOP_W-1:0] c_alu_and  = ALUOP_W'(4'b0111);
    localparam logic [ALUOP_W-1:0] c_alu_or   = ALUOP_W'(4'b1000);
    localparam logic [ALUOP_W-1:0] c_alu_xor  = ALUOP_W'(4'b1001);
    localparam logic [ALUOP_W-1:0] c_alu_nor  = ALUOP_W'(4'b1010);
    localparam logic [ALUOP_W-1:0] c_alu_slt  = ALUOP_W'(4'b1011);
    localparam logic [ALUOP_W-1:0] c_alu_sltu = ALUOP_W'(4'b1100);
    localparam logic [ALUOP_W-1:0] c_alu_none = ALUOP_W'(4'b1101);

    localparam logic [1:0] c_ext_shamt = 2'b10;
    localparam logic [1:0] c_ext_zero  = 2'b01;

    // ------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               alusrc;
        logic [1:0]         extop;
        logic               j;
        logic               jal;
        logic               jr;
        logic               beq;
        logic               bne;
        logic               blez;
        logic               syscall;
        logic               memwrite;
        logic               sh;
        logic               memtoreg;
        logic               regwrite;
        logic [4:0]         wreg;
    } id_ex_t;

    typedef struct packed {
        logic       memwrite;
        logic       sh;
        logic       memtoreg;
        logic       regwrite;
        logic       jal;
        logic [4:0] wreg;
    } ex_mem_t;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       jal;
        logic [4:0] wreg;
    } mem_wb_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_unused_shamt;

    id_ex_t     w_dec;
    logic       w_known;
    logic       w_load_use;
    logic       w_exit;
    logic       w_pc_stall;
    logic       w_ifid_flush;
    logic       w_load_idex;

    id_ex_t           idex_q,      idex_d;
    ex_mem_t          exmem_q,     exmem_d;
    mem_wb_t          memwb_q,     memwb_d;
    state_t           state_q,     state_d;
    logic [1:0]       drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
`ifdef ILLEGAL_TRAP_EN
    logic             w_illegal;
    logic             ex_illegal_q, ex_illegal_d;
    logic             illegal_q,    illegal_d;
`endif

    assign w_op    = bus.id_instr[31:26];
    assign w_rs    = bus.id_instr[25:21];
    assign w_rt    = bus.id_instr[20:16];
    assign w_rd    = bus.id_instr[15:11];
    assign w_funct = bus.id_instr[5:0];
    // Shift amount is consumed by the datapath, not by control.
    assign w_unused_shamt = ^bus.id_instr[10:6];

    // ------------------------------------------------------------------
    // ID-stage decoder
    // ------------------------------------------------------------------
    always_comb begin
        w_dec   = '0;
        w_known = 1'b0;
        case (w_op)
            c_op_rtype: begin
                case (w_funct)
                    c_fn_add, c_fn_addu: begin
                        w_known = 1'b1; w_dec.aluop = c_alu_add;  w_dec.regwrite = 1'b1;
                    end
                    c_fn_sub: begin
                        w_known = 1'b1; w_dec.aluop = c_alu_sub;  w_dec.regwrite = 1'b1;
                    end
                    c_fn_and: begin
                        w_known = 1'b1; w_dec.aluop = c_alu_and;  w_dec.regwrite = 1'b1;
                    end
                    c_fn_or: begin
                        w_known = 1'b1; w_dec.aluop = c_alu_or;   w_dec.regwrite = 1'b1;
                    end
                    c_fn_xor: begin
                        w_known = 1'b1; w_dec.aluop = c_alu_xor;  w_dec.regwrite = 1'b1;
                    end
                    c_fn_nor: begin
                        w_known = 1'b1; w_dec.aluop = c_alu_nor;  w_dec.regwrite = 1'b1;
                    end
                    c_fn_slt: begin
                        w_known = 1'b1; w_dec.aluop = c_alu_slt;  w_dec.regwrite = 1'b1;
                    end
                    c_fn_sltu: begin
                        w_known = 1'b1; w_dec.aluop = c_alu_sltu; w_dec.regwrite = 1'b1;
                    end
                    // Shifts route shamt through the immediate operand path.
                    c_fn_sll: begin
                        w_known = 1'b1; w_dec.aluop = c_alu_sll; w_dec.regwrite = 1'b1;
                        w_dec.alusrc = 1'b1; w_dec.extop = c_ext_shamt;
                    end
                    c_fn_srl: begin
                        w_known = 1'b1; w_dec.aluop = c_alu_srl; w_dec.regwrite = 1'b1;
                        w_dec.alusrc = 1'b1; w_dec.extop = c_ext_shamt;
                    end
                    c_fn_sra: begin
                        w_known = 1'b1; w_dec.aluop = c_alu_sra; w_dec.regwrite = 1'b1;
                        w_dec.alusrc = 1'b1; w_dec.extop = c_ext_shamt;
                    end
                    c_fn_jr: begin
                        w_known = 1'b1; w_dec.aluop = c_alu_none; w_dec.jr = 1'b1;
                    end
                    c_fn_syscall: begin
                        w_known = 1'b1; w_dec.aluop = c_alu_none; w_dec.syscall = 1'b1;
                    end
                    default: ;
                endcase
            end
            c_op_addi, c_op_addiu: begin
                w_known = 1'b1; w_dec.aluop = c_alu_add;
                w_dec.alusrc = 1'b1; w_dec.regwrite = 1'b1;
            end
            c_op_andi: begin
                w_known = 1'b1; w_dec.aluop = c_alu_and;
                w_dec.alusrc = 1'b1; w_dec.regwrite = 1'b1;
            end
            c_op_ori: begin
                w_known = 1'b1; w_dec.aluop = c_alu_or; w_dec.extop = c_ext_zero;
                w_dec.alusrc = 1'b1; w_dec.regwrite = 1'b1;
            end
            c_op_slti: begin
                w_known = 1'b1; w_dec.aluop = c_alu_slt;
                w_dec.alusrc = 1'b1; w_dec.regwrite = 1'b1;
            end
            c_op_sltiu: begin
                w_known = 1'b1; w_dec.aluop = c_alu_sltu;
                w_dec.alusrc = 1'b1; w_dec.regwrite = 1'b1;
            end
            c_op_beq: begin
                w_known = 1'b1; w_dec.aluop = c_alu_none; w_dec.beq = 1'b1;
            end
            c_op_bne: begin
                w_known = 1'b1; w_dec.aluop = c_alu_none; w_dec.bne = 1'b1;
            end
            c_op_blez: begin
                w_known = 1'b1; w_dec.aluop = c_alu_none; w_dec.blez = 1'b1;
            end
            c_op_j: begin
                w_known = 1'b1; w_dec.aluop = c_alu_none; w_dec.j = 1'b1;
            end
            c_op_jal: begin
                w_known = 1'b1; w_dec.aluop = c_alu_none; w_dec.jal = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            c_op_lw: begin
                w_known = 1'b1; w_dec.aluop = c_alu_add; w_dec.alusrc = 1'b1;
                w_dec.memtoreg = 1'b1; w_dec.regwrite = 1'b1;
            end
            c_op_sw: begin
                w_known = 1'b1; w_dec.aluop = c_alu_add; w_dec.alusrc = 1'b1;
                w_dec.memwrite = 1'b1;
            end
            c_op_sh: begin
                w_known = 1'b1; w_dec.aluop = c_alu_add; w_dec.alusrc = 1'b1;
                w_dec.memwrite = 1'b1; w_dec.sh = 1'b1;
            end
            default: ;
        endcase

        // Destination register only exists for writers; wreg stays 0 otherwise.
        if (w_dec.regwrite) begin
            if (w_op == c_op_rtype)
                w_dec.wreg = w_rd;
            else if (w_op == c_op_jal)
                w_dec.wreg = 5'd31;
            else
                w_dec.wreg = w_rt;
        end

        if (!bus.id_valid || !w_known)
            w_dec = '0;
    end

`ifdef ILLEGAL_TRAP_EN
    assign w_illegal = bus.id_valid && !w_known;
`endif

    // ------------------------------------------------------------------
    // Hazard / exit detection
    // ------------------------------------------------------------------
    assign w_load_use = bus.id_valid && idex_q.memtoreg && (idex_q.wreg != 5'd0) &&
                        ((idex_q.wreg == w_rs) || (idex_q.wreg == w_rt));

    assign w_exit = idex_q.syscall && bus.ex_sys_exit;

    // ------------------------------------------------------------------
    // FSM next state, stall/flush and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        w_pc_stall   = 1'b0;
        w_ifid_flush = 1'b0;
        w_load_idex  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_d    = illegal_q;
`endif
        case (state_q)
            S_RUN: begin
`ifdef ILLEGAL_TRAP_EN
                if (ex_illegal_q) begin
                    w_ifid_flush = 1'b1;
                    illegal_d    = 1'b1;
                    state_d      = S_HALT;
                end else
`endif
                if (w_exit) begin
                    // Younger instructions behind the exit are discarded.
                    w_ifid_flush = 1'b1;
                    drain_cnt_d  = 2'(DRAIN_CYC);
                    state_d      = S_DRAIN;
                end else if (bus.ex_redirect) begin
                    // Redirect wins over a load-use hazard: the stalled
                    // instruction is on the wrong path anyway.
                    w_ifid_flush = 1'b1;
                    flush_cnt_d  = sat_inc(flush_cnt_q);
                end else if (w_load_use) begin
                    w_pc_stall   = 1'b1;
                    stall_cnt_d  = sat_inc(stall_cnt_q);
                end else begin
                    w_load_idex  = 1'b1;
                end
            end
            S_DRAIN: begin
                w_pc_stall  = 1'b1;
                drain_cnt_d = drain_cnt_q - 2'd1;
                if (drain_cnt_q == 2'd1)
                    state_d = S_HALT;
            end
            S_HALT: begin
                w_pc_stall = 1'b1;
                if (bus.resume) begin
                    state_d = S_RUN;
`ifdef ILLEGAL_TRAP_EN
                    illegal_d = 1'b0;
`endif
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline register next values
    // ------------------------------------------------------------------
    always_comb begin
        idex_d           = w_load_idex ? w_dec : '0;

        exmem_d.memwrite = idex_q.memwrite;
        exmem_d.sh       = idex_q.sh;
        exmem_d.memtoreg = idex_q.memtoreg;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.jal      = idex_q.jal;
        exmem_d.wreg     = idex_q.wreg;

        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.memtoreg = exmem_q.memtoreg;
        memwb_d.jal      = exmem_q.jal;
        memwb_d.wreg     = exmem_q.wreg;
    end

`ifdef ILLEGAL_TRAP_EN
    assign ex_illegal_d = w_load_idex && w_illegal;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q       <= '0;
            exmem_q      <= '0;
            memwb_q      <= '0;
            state_q      <= S_RUN;
            drain_cnt_q  <= 2'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
`ifdef ILLEGAL_TRAP_EN
            ex_illegal_q <= 1'b0;
            illegal_q    <= 1'b0;
`endif
        end else begin
            idex_q       <= idex_d;
            exmem_q      <= exmem_d;
            memwb_q      <= memwb_d;
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
`ifdef ILLEGAL_TRAP_EN
            ex_illegal_q <= ex_illegal_d;
            illegal_q    <= illegal_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pc_stall     = w_pc_stall;
    assign bus.ifid_stall   = w_pc_stall;
    assign bus.ifid_flush   = w_ifid_flush;

    assign bus.ex_aluop     = idex_q.aluop;
    assign bus.ex_alusrc    = idex_q.alusrc;
    assign bus.ex_extop     = idex_q.extop;
    assign bus.ex_j         = idex_q.j;
    assign bus.ex_jal       = idex_q.jal;
    assign bus.ex_jr        = idex_q.jr;
    assign bus.ex_beq       = idex_q.beq;
    assign bus.ex_bne       = idex_q.bne;
    assign bus.ex_blez      = idex_q.blez;
    assign bus.ex_syscall   = idex_q.syscall;
    assign bus.ex_wreg      = idex_q.wreg;

    assign bus.mem_memwrite = exmem_q.memwrite;
    assign bus.mem_sh       = exmem_q.sh;
    assign bus.mem_memtoreg = exmem_q.memtoreg;
    assign bus.mem_regwrite = exmem_q.regwrite;
    assign bus.mem_wreg     = exmem_q.wreg;

    assign bus.wb_regwrite  = memwb_q.regwrite;
    assign bus.wb_memtoreg  = memwb_q.memtoreg;
    assign bus.wb_jal       = memwb_q.jal;
    assign bus.wb_wreg      = memwb_q.wreg;

    assign bus.halt         = (state_q == S_HALT);
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal      = illegal_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe_unit
// Purpose  : Self-checking bench for ctrl_pipe_unit: a table of per-cycle
//            vectors for the pipeline/hazard/redirect behaviour followed by
//            hand-written sequences for exit/drain/halt, counter saturation
//            and asynchronous reset. Counters are built 2 bits wide so that
//            saturation is reachable in a few cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe_unit;
    localparam int ALUOP_W   = 4;
    localparam int CNT_W     = 2;
    localparam int DRAIN_CYC = 2;

    localparam logic [31:0] c_add3   = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] c_lw4    = 32'h8C64_0000; // lw  $4,0($3)
    localparam logic [31:0] c_lw5    = 32'h8C05_0000; // lw  $5,0($0)
    localparam logic [31:0] c_add6   = 32'h00A1_3020; // add $6,$5,$1
    localparam logic [31:0] c_sub7   = 32'h0022_3822; // sub $7,$1,$2
    localparam logic [31:0] c_jal    = 32'h0C00_0010; // jal
    localparam logic [31:0] c_ori8   = 32'h3408_0005; // ori $8,$0,5
    localparam logic [31:0] c_xor10  = 32'h0022_5026; // xor $10,$1,$2
    localparam logic [31:0] c_sll9   = 32'h0002_4900; // sll $9,$2,4
    localparam logic [31:0] c_undef  = 32'hFC00_0000; // op 0x3F
    localparam logic [31:0] c_sw     = 32'hAC41_0000; // sw  $1,0($2)
    localparam logic [31:0] c_beq    = 32'h1022_0004; // beq $1,$2
    localparam logic [31:0] c_sysc   = 32'h0000_000C; // syscall

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ctrl_pipe_unit_if #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

    ctrl_pipe_unit #(
        .ALUOP_W  (ALUOP_W),
        .CNT_W    (CNT_W),
        .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        redir;
        logic        stall;
        logic        flush;
        logic [3:0]  aluop;
        logic [4:0]  exw;
        logic [4:0]  memw;
        logic        memtr;
        logic        wbrw;
        logic [4:0]  wbw;
        logic        wbjal;
        logic [1:0]  scnt;
        logic [1:0]  fcnt;
    } vec_t;

    vec_t tv [16];

    function automatic vec_t mk(input logic [31:0] instr, input logic valid, input logic redir,
                                input logic stall, input logic flush, input logic [3:0] aluop,
                                input logic [4:0] exw, input logic [4:0] memw, input logic memtr,
                                input logic wbrw, input logic [4:0] wbw, input logic wbjal,
                                input logic [1:0] scnt, input logic [1:0] fcnt);
        vec_t v;
        v.instr = instr; v.valid = valid; v.redir = redir; v.stall = stall; v.flush = flush;
        v.aluop = aluop; v.exw = exw; v.memw = memw; v.memtr = memtr; v.wbrw = wbrw;
        v.wbw = wbw; v.wbjal = wbjal; v.scnt = scnt; v.fcnt = fcnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs on the falling edge, settle before returning.
    task automatic drive(input logic [31:0] instr, input logic valid, input logic redir,
                         input logic sysx, input logic resume);
        @(negedge clk);
        bus.id_instr    = instr;
        bus.id_valid    = valid;
        bus.ex_redirect = redir;
        bus.ex_sys_exit = sysx;
        bus.resume      = resume;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              instr    v  r  stl fl alu exw memw mt rw wbw jal sc fc
        tv[0]  = mk(c_add3,  1, 0, 0, 0, 5,  3,  0, 0, 0, 0,  0, 0, 0);
        tv[1]  = mk(c_lw4,   1, 0, 0, 0, 5,  4,  3, 0, 0, 0,  0, 0, 0);
        tv[2]  = mk(c_lw5,   1, 0, 0, 0, 5,  5,  4, 1, 1, 3,  0, 0, 0);
        tv[3]  = mk(c_add6,  1, 0, 1, 0, 0,  0,  5, 1, 1, 4,  0, 1, 0);
        tv[4]  = mk(c_add6,  1, 0, 0, 0, 5,  6,  0, 0, 1, 5,  0, 1, 0);
        tv[5]  = mk(c_sub7,  1, 0, 0, 0, 6,  7,  6, 0, 0, 0,  0, 1, 0);
        tv[6]  = mk(c_lw5,   1, 0, 0, 0, 5,  5,  7, 0, 1, 6,  0, 1, 0);
        tv[7]  = mk(c_add6,  1, 1, 0, 1, 0,  0,  5, 1, 1, 7,  0, 1, 1);
        tv[8]  = mk(c_jal,   1, 0, 0, 0, 13, 31, 0, 0, 1, 5,  0, 1, 1);
        tv[9]  = mk(c_ori8,  1, 0, 0, 0, 8,  8,  31,0, 0, 0,  0, 1, 1);
        tv[10] = mk(c_xor10, 1, 0, 0, 0, 9,  10, 8, 0, 1, 31, 1, 1, 1);
        tv[11] = mk(c_sll9,  1, 0, 0, 0, 0,  9,  10,0, 1, 8,  0, 1, 1);
        tv[12] = mk(c_undef, 1, 0, 0, 0, 0,  0,  9, 0, 1, 10, 0, 1, 1);
        tv[13] = mk(c_sw,    1, 0, 0, 0, 5,  0,  0, 0, 1, 9,  0, 1, 1);
        tv[14] = mk(c_beq,   1, 0, 0, 0, 13, 0,  0, 0, 0, 0,  0, 1, 1);
        tv[15] = mk(c_add3,  0, 0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 1, 1);

        bus.id_instr = '0; bus.id_valid = 1'b0; bus.ex_redirect = 1'b0;
        bus.ex_sys_exit = 1'b0; bus.resume = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ex_aluop",  bus.ex_aluop, 0);
        chk("reset ex_wreg",   bus.ex_wreg, 0);
        chk("reset mem_wreg",  bus.mem_wreg, 0);
        chk("reset wb_regwr",  bus.wb_regwrite, 0);
        chk("reset halt",      bus.halt, 0);
        chk("reset stall_cnt", bus.stall_cnt, 0);
        chk("reset flush_cnt", bus.flush_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven pipeline vectors ----------------
        for (int i = 0; i < 16; i++) begin
            drive(tv[i].instr, tv[i].valid, tv[i].redir, 1'b0, 1'b0);
            chk($sformatf("v%0d pc_stall", i),   bus.pc_stall,   tv[i].stall);
            chk($sformatf("v%0d ifid_stall", i), bus.ifid_stall, tv[i].stall);
            chk($sformatf("v%0d ifid_flush", i), bus.ifid_flush, tv[i].flush);
            tick();
            chk($sformatf("v%0d ex_aluop", i),     bus.ex_aluop,     tv[i].aluop);
            chk($sformatf("v%0d ex_wreg", i),      bus.ex_wreg,      tv[i].exw);
            chk($sformatf("v%0d mem_wreg", i),     bus.mem_wreg,     tv[i].memw);
            chk($sformatf("v%0d mem_memtoreg", i), bus.mem_memtoreg, tv[i].memtr);
            chk($sformatf("v%0d wb_regwrite", i),  bus.wb_regwrite,  tv[i].wbrw);
            chk($sformatf("v%0d wb_wreg", i),      bus.wb_wreg,      tv[i].wbw);
            chk($sformatf("v%0d wb_jal", i),       bus.wb_jal,       tv[i].wbjal);
            chk($sformatf("v%0d stall_cnt", i),    bus.stall_cnt,    tv[i].scnt);
            chk($sformatf("v%0d flush_cnt", i),    bus.flush_cnt,    tv[i].fcnt);
        end

        // ---------------- exit syscall -> drain -> halt -> resume -------
        drive(c_sysc, 1, 0, 0, 0);
        tick();
        chk("exit syscall in EX", bus.ex_syscall, 1);
        drive(c_add3, 1, 0, 1, 0);
        chk("exit flush",    bus.ifid_flush, 1);
        chk("exit no stall", bus.pc_stall, 0);
        tick();
        chk("exit bubble ex_wreg", bus.ex_wreg, 0);
        chk("drain1 halt", bus.halt, 0);
        drive(c_add3, 1, 1, 0, 0);          // redirect during drain must not count
        chk("drain1 stall", bus.pc_stall, 1);
        chk("drain1 no flush", bus.ifid_flush, 0);
        tick();
        chk("drain2 halt", bus.halt, 0);
        drive(c_add3, 1, 0, 0, 0);
        chk("drain2 stall", bus.ifid_stall, 1);
        tick();
        chk("halt asserted", bus.halt, 1);
        chk("drain flush_cnt frozen", bus.flush_cnt, 1);
        drive(c_add3, 1, 0, 0, 0);
        chk("halt stall", bus.pc_stall, 1);
        tick();
        chk("halt held", bus.halt, 1);
        drive(c_add3, 1, 0, 0, 1);
        tick();
        chk("resume halt", bus.halt, 0);
        chk("resume pc_stall", bus.pc_stall, 0);

        // ---------------- syscall without exit is a no-op ---------------
        drive(c_sysc, 1, 0, 0, 0);
        tick();
        drive(c_add3, 1, 0, 0, 0);
        chk("noexit flush", bus.ifid_flush, 0);
        tick();
        chk("noexit ex_wreg", bus.ex_wreg, 3);
        tick();
        tick();
        chk("noexit halt", bus.halt, 0);

        // ---------------- flush counter saturation ----------------------
        for (int k = 0; k < 3; k++) begin
            drive(c_add3, 1, 1, 0, 0);
            tick();
            chk($sformatf("sat flush_cnt %0d", k), bus.flush_cnt, (k == 0) ? 2 : 3);
        end

        // ---------------- async reset mid-traffic -----------------------
        drive(c_lw4, 1, 0, 0, 0);
        tick();
        chk("pre-reset ex_wreg", bus.ex_wreg, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("async ex_wreg",   bus.ex_wreg, 0);
        chk("async mem_wreg",  bus.mem_wreg, 0);
        chk("async stall_cnt", bus.stall_cnt, 0);
        chk("async flush_cnt", bus.flush_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- async reset mid-HALT --------------------------
        drive(c_sysc, 1, 0, 0, 0);
        tick();
        drive(c_add3, 1, 0, 1, 0);
        tick();
        drive(c_add3, 1, 0, 0, 0);
        tick();
        tick();
        chk("halt again", bus.halt, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async halt clear", bus.halt, 0);
        chk("async pc_stall",   bus.pc_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
